// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues a request-to-send, then shifts one command byte
// (LSB first, odd parity, stop) on device-generated falling clock edges and
// checks the device acknowledge. The pins are open-drain: an *_oe of 1 pulls
// the line low, 0 releases it.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_START     = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_t;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

   state_t             state_q,     state_d;
   logic [INH_W-1:0]   inh_cnt_q,   inh_cnt_d;
   logic [3:0]         start_cnt_q, start_cnt_d;
   logic [3:0]         edge_cnt_q,  edge_cnt_d;
   logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
   logic [8:0]         shift_q,     shift_d;
   logic               clk_oe_q,    clk_oe_d;
   logic               dat_oe_q,    dat_oe_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               err_q,       err_d;

   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;
   logic clk_fall_s;
   logic timeout_s;

   // Two-flop synchronizers for the raw pins plus the previous synced clock.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_in;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign clk_fall_s = clk_prev_q & ~clk_s2_q;
   assign timeout_s  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Next-state, counter, shift-register and output computation.
   always_comb begin
      state_d     = state_q;
      inh_cnt_d   = inh_cnt_q;
      start_cnt_d = start_cnt_q;
      edge_cnt_d  = edge_cnt_q;
      to_cnt_d    = to_cnt_q;
      shift_d     = shift_q;
      clk_oe_d    = clk_oe_q;
      dat_oe_d    = dat_oe_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (tx_start) begin
               shift_d   = {odd_parity(tx_data), tx_data};
               inh_cnt_d = '0;
               clk_oe_d  = 1'b1;
               state_d   = ST_INHIBIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
               dat_oe_d    = 1'b1;
               start_cnt_d = 4'd0;
               state_d     = ST_START;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
         end
         ST_START: begin
            if (start_cnt_q == 4'd15) begin
               // Release the clock; data stays low as the start bit.
               clk_oe_d   = 1'b0;
               edge_cnt_d = 4'd0;
               to_cnt_d   = '0;
               state_d    = ST_SHIFT;
            end else begin
               start_cnt_d = start_cnt_q + 4'd1;
            end
         end
         ST_SHIFT: begin
            if (timeout_s) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (clk_fall_s) begin
                  edge_cnt_d = edge_cnt_q + 4'd1;
                  if (edge_cnt_q == 4'd9) begin
                     // Tenth edge: release data for the stop bit.
                     dat_oe_d = 1'b0;
                     state_d  = ST_ACK;
                  end else begin
                     // Edges 1..9 present data bits 0..7, then parity.
                     dat_oe_d = ~shift_q[0];
                     shift_d  = {1'b0, shift_q[8:1]};
                  end
               end else begin
                  edge_cnt_d = edge_cnt_q;
               end
            end
         end
         ST_ACK: begin
            if (timeout_s) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (clk_fall_s) begin
                  if (!dat_s2_q) begin
                     state_d = ST_WAIT_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (timeout_s) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (clk_s2_q && dat_s2_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT_IDLE;
               end
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Controller state, counters and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         inh_cnt_q   <= '0;
         start_cnt_q <= 4'd0;
         edge_cnt_q  <= 4'd0;
         to_cnt_q    <= '0;
         shift_q     <= 9'd0;
         clk_oe_q    <= 1'b0;
         dat_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         inh_cnt_q   <= inh_cnt_d;
         start_cnt_q <= start_cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         to_cnt_q    <= to_cnt_d;
         shift_q     <= shift_d;
         clk_oe_q    <= clk_oe_d;
         dat_oe_q    <= dat_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign tx_err     = err_q;

endmodule
